// File: rtl/patch_sched_pkg.sv
// Shared types and constants for the patch stream scheduler:
// FSM state encoding, patchifier state codes and default frame geometry.
package patch_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_STREAM  = 3'd3,
    S_RELEASE = 3'd4
  } sched_state_t;

  localparam logic [2:0] PST_IDLE           = 3'b000;
  localparam logic [2:0] PST_PREPROCESSING  = 3'b001;
  localparam logic [2:0] PST_PROCESSING     = 3'b010;
  localparam logic [2:0] PST_POSTPROCESSING = 3'b011;
  localparam logic [2:0] PST_DONE           = 3'b100;

  localparam int DEF_PIXEL_WIDTH       = 24;
  localparam int DEF_TOTAL_NUM_PATCHES = 16;
  localparam int DEF_PATCH_VECTOR_SIZE = 256;
  localparam int DEF_TIMEOUT_CYCLES    = 65536;

endpackage

// File: rtl/patch_index_counter.sv
// Two-level wrapping (patch, pos) read-address counter; pos is the minor index.
// all_wrap flags the final address of the frame so the caller can end the stream.
module patch_index_counter #(
  parameter int NUM_PATCHES = 16,
  parameter int VEC_SIZE    = 256,
  localparam int PIDX_W     = $clog2(NUM_PATCHES),
  localparam int POS_W      = $clog2(VEC_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [POS_W-1:0]  pos,
  output logic [PIDX_W-1:0] patch,
  output logic              pos_wrap,
  output logic              all_wrap
);

  localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(VEC_SIZE - 1);
  localparam logic [PIDX_W-1:0] PATCH_MAX = PIDX_W'(NUM_PATCHES - 1);

  logic [POS_W-1:0]  pos_reg;
  logic [PIDX_W-1:0] patch_reg;

  assign pos      = pos_reg;
  assign patch    = patch_reg;
  assign pos_wrap = (pos_reg == POS_MAX);
  assign all_wrap = pos_wrap && (patch_reg == PATCH_MAX);

  // Explicit wrap on all_wrap keeps non-power-of-two patch counts in range.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pos_reg   <= '0;
      patch_reg <= '0;
    end else if (inc) begin
      if (pos_wrap) begin
        pos_reg   <= '0;
        patch_reg <= all_wrap ? '0 : patch_reg + 1'b1;
      end else begin
        pos_reg <= pos_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/patch_stream_scheduler.sv
// Launches the patchifier, waits for DONE, streams every patch pixel downstream, then releases.
// Optional WAIT-state watchdog is built when PATCH_SCHED_TIMEOUT_EN is defined.
module patch_stream_scheduler
  import patch_sched_pkg::*;
#(
  parameter int PIXEL_WIDTH       = DEF_PIXEL_WIDTH,
  parameter int TOTAL_NUM_PATCHES = DEF_TOTAL_NUM_PATCHES,
  parameter int PATCH_VECTOR_SIZE = DEF_PATCH_VECTOR_SIZE,
  parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES,
  localparam int PIDX_W           = $clog2(TOTAL_NUM_PATCHES),
  localparam int POS_W            = $clog2(PATCH_VECTOR_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   start_ready,
  output logic                   patchifier_en,
  input  logic [2:0]             patchifier_state,
  output logic                   output_taken,
  output logic [PIDX_W-1:0]      rd_patch_idx,
  output logic [POS_W-1:0]       rd_pos_idx,
  input  logic [PIXEL_WIDTH-1:0] rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] out_data,
  output logic [PIDX_W-1:0]      out_patch_idx,
  output logic                   out_last,
  output logic                   out_frame_last,
  output logic                   frame_done,
  output logic                   timeout_err
);

  sched_state_t state_reg, state_next;
  logic         frame_done_reg;
  logic         beat_fire;
  logic         cnt_clr;
  logic         pos_wrap;
  logic         all_wrap;

  assign cnt_clr   = (state_reg == S_IDLE) && start;
  assign beat_fire = (state_reg == S_STREAM) && out_ready;

  patch_index_counter #(
    .NUM_PATCHES (TOTAL_NUM_PATCHES),
    .VEC_SIZE    (PATCH_VECTOR_SIZE)
  ) u_idx (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .inc      (beat_fire),
    .pos      (rd_pos_idx),
    .patch    (rd_patch_idx),
    .pos_wrap (pos_wrap),
    .all_wrap (all_wrap)
  );

`ifdef PATCH_SCHED_TIMEOUT_EN
  logic [31:0] wdog_reg;
  logic        timeout_err_reg;
  logic        wdog_expire;

  assign wdog_expire = (state_reg == S_WAIT) && (patchifier_state != PST_DONE)
                       && (wdog_reg == 32'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_reg;

  // Counter is held at zero outside WAIT, so every WAIT entry starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_reg        <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      wdog_reg <= (state_reg == S_WAIT) ? wdog_reg + 32'd1 : 32'd0;
      if (wdog_expire) timeout_err_reg <= 1'b1;
    end
  end
`else
  // No watchdog: constant 0 for any legal (positive) TIMEOUT_CYCLES.
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start) state_next = S_LAUNCH;
      S_LAUNCH:  state_next = S_WAIT;
      S_WAIT: begin
        if (patchifier_state == PST_DONE) state_next = S_STREAM;
`ifdef PATCH_SCHED_TIMEOUT_EN
        else if (wdog_expire) state_next = S_IDLE;
`endif
      end
      S_STREAM:  if (beat_fire && all_wrap) state_next = S_RELEASE;
      S_RELEASE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      frame_done_reg <= (state_reg == S_RELEASE);
    end
  end

  assign start_ready    = (state_reg == S_IDLE);
  assign patchifier_en  = (state_reg == S_LAUNCH);
  assign output_taken   = (state_reg == S_RELEASE);
  assign frame_done     = frame_done_reg;
  assign out_valid      = (state_reg == S_STREAM);
  assign out_data       = rd_data;
  assign out_patch_idx  = rd_patch_idx;
  assign out_last       = out_valid && pos_wrap;
  assign out_frame_last = out_valid && all_wrap;

endmodule
